// File: rtl/parking_meter_core_pkg.sv
// Shared constants for the parking meter: BCD add/load amounts, limits,
// display modes and active-low segment codes (bit0 = a ... bit6 = g).
package parking_meter_core_pkg;

    localparam int unsigned TIME_W = 16;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned NUM_AN = 4;

    localparam logic [TIME_W-1:0] ADD1_BCD     = 16'h0060;
    localparam logic [TIME_W-1:0] ADD2_BCD     = 16'h0120;
    localparam logic [TIME_W-1:0] ADD3_BCD     = 16'h0180;
    localparam logic [TIME_W-1:0] ADD4_BCD     = 16'h0300;
    localparam logic [TIME_W-1:0] LOAD1_BCD    = 16'h0015;
    localparam logic [TIME_W-1:0] LOAD2_BCD    = 16'h0150;
    localparam logic [TIME_W-1:0] MAX_TIME_BCD = 16'h9999;
    localparam logic [TIME_W-1:0] FLASH_BCD    = 16'h0180;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        DISP_STEADY = 2'd0,
        DISP_SLOW   = 2'd1,
        DISP_FAST   = 2'd2
    } disp_mode_e;

endpackage

// File: rtl/parking_meter_core_bcd_to_7seg.sv
// BCD digit to active-low seven-segment decoder; codes 10-15 blank the digit.
module bcd_to_7seg
    import parking_meter_core_pkg::*;
(
    input  logic [DIG_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/parking_meter_core.sv
// Parking meter: 4-digit BCD countdown with coin adds, preset loads,
// one-second prescaler, flash modes and a scan-multiplexed 7-seg display.
module parking_meter_core
    import parking_meter_core_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 100
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             add1,
    input  logic             add2,
    input  logic             add3,
    input  logic             add4,
    input  logic             rst1,
    input  logic             rst2,
    output logic [SEG_W-1:0] led_seg,
    output logic             a1,
    output logic             a2,
    output logic             a3,
    output logic             a4,
    output logic [DIG_W-1:0] val1,
    output logic [DIG_W-1:0] val2,
    output logic [DIG_W-1:0] val3,
    output logic [DIG_W-1:0] val4
);

    localparam int unsigned PRE_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLKS_PER_SEC / 2);

    logic [TIME_W-1:0] time_q, time_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              par_q, par_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        prev_q, prev_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [NUM_AN-1:0] an_q, an_d;

    logic [3:0]        add_c, edge_c;
    logic [TIME_W-1:0] sum_c;
    logic              tick_c, on_c;
    disp_mode_e        mode_c;
    logic [DIG_W-1:0]  digit_c;
    logic [SEG_W-1:0]  dec_seg_c;

    // Digit-wise BCD add; bit 16 is the carry out of the thousands digit.
    function automatic logic [TIME_W:0] bcd_add(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
        logic [4:0]        s;
        logic              c;
        logic [TIME_W-1:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
            c = (s > 5'd9);
            if (c) s = s + 5'd6;
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    function automatic logic [TIME_W-1:0] bcd_add_sat(input logic [TIME_W-1:0] a,
                                                      input logic [TIME_W-1:0] b);
        logic [TIME_W:0] s;
        s = bcd_add(a, b);
        return s[TIME_W] ? MAX_TIME_BCD : s[TIME_W-1:0];
    endfunction

    // Decrement by one second, holding at zero.
    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] a);
        logic [TIME_W-1:0] r;
        logic              borrow;
        r      = a;
        borrow = (a != '0);
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign add_c   = {add4, add3, add2, add1};
    // Scan index 0 selects the thousands digit (a1).
    assign digit_c = time_q[{~idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd_i (digit_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        edge_c = add_c & ~prev_q;
        sum_c  = '0;
        if (edge_c[0]) sum_c = bcd_add_sat(sum_c, ADD1_BCD);
        if (edge_c[1]) sum_c = bcd_add_sat(sum_c, ADD2_BCD);
        if (edge_c[2]) sum_c = bcd_add_sat(sum_c, ADD3_BCD);
        if (edge_c[3]) sum_c = bcd_add_sat(sum_c, ADD4_BCD);
        tick_c = (pre_q == PRE_LAST);

        if (time_q >= FLASH_BCD)  mode_c = DISP_STEADY;
        else if (time_q != '0)    mode_c = DISP_SLOW;
        else                      mode_c = DISP_FAST;

        case (mode_c)
            DISP_STEADY: on_c = 1'b1;
            DISP_SLOW:   on_c = ~par_q;
            default:     on_c = (pre_q < PRE_HALF);
        endcase

        time_d = time_q;
        pre_d  = pre_q;
        par_d  = par_q;
        idx_d  = idx_q + 2'd1;
        prev_d = add_c;
        seg_d  = on_c ? dec_seg_c : SEG_OFF;
        an_d   = on_c ? ~(4'b1000 >> idx_q) : 4'hF;

        if (rst1) begin
            time_d = LOAD1_BCD;
            pre_d  = '0;
            par_d  = 1'b0;
        end else if (rst2) begin
            time_d = LOAD2_BCD;
            pre_d  = '0;
            par_d  = 1'b0;
        end else begin
            if (tick_c) begin
                pre_d  = '0;
                par_d  = ~par_q;
                time_d = bcd_dec(time_q);
            end else begin
                pre_d  = pre_q + PRE_W'(1);
            end
            time_d = bcd_add_sat(time_d, sum_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
            pre_q  <= '0;
            par_q  <= 1'b0;
            idx_q  <= '0;
            prev_q <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= 4'hF;
        end else begin
            time_q <= time_d;
            pre_q  <= pre_d;
            par_q  <= par_d;
            idx_q  <= idx_d;
            prev_q <= prev_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign led_seg = seg_q;
    assign a1      = an_q[3];
    assign a2      = an_q[2];
    assign a3      = an_q[1];
    assign a4      = an_q[0];
    assign val1    = time_q[15:12];
    assign val2    = time_q[11:8];
    assign val3    = time_q[7:4];
    assign val4    = time_q[3:0];

endmodule

// File: tb/tb_parking_meter_core.sv
// Bench for parking_meter_core: directed scenarios plus random traffic,
// every cycle compared against an integer-seconds reference model.
module tb_parking_meter_core;

    localparam int unsigned CPS = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] add  = 4'h0;
    logic       rst1 = 1'b0;
    logic       rst2 = 1'b0;
    logic [6:0] led_seg;
    logic       a1, a2, a3, a4;
    logic [3:0] val1, val2, val3, val4;

    int n_checks = 0;
    int n_errors = 0;

    int         m_time = 0;
    int         m_pre  = 0;
    int         m_par  = 0;
    int         m_idx  = 0;
    logic [3:0] m_prev = 4'h0;
    logic [6:0] m_seg  = 7'h7F;
    logic [3:0] m_an   = 4'hF;
    int         add_rate = 8;

    always #5 clk = ~clk;

    parking_meter_core #(.CLKS_PER_SEC(CPS)) dut (
        .clk     (clk),
        .rst     (rst),
        .add1    (add[0]),
        .add2    (add[1]),
        .add3    (add[2]),
        .add4    (add[3]),
        .rst1    (rst1),
        .rst2    (rst2),
        .led_seg (led_seg),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .a4      (a4),
        .val1    (val1),
        .val2    (val2),
        .val3    (val3),
        .val4    (val4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 1000 % 10), 4'(t / 100 % 10), 4'(t / 10 % 10), 4'(t % 10)};
    endfunction

    // One clock of the meter in whole seconds; display reflects the pre-edge state.
    task automatic model_step();
        int p10[4];
        int sum;
        bit on;
        p10 = '{1000, 100, 10, 1};
        if (rst) begin
            m_time = 0; m_pre = 0; m_par = 0; m_idx = 0;
            m_prev = 4'h0; m_seg = 7'h7F; m_an = 4'hF;
        end else begin
            if (m_time >= 180)    on = 1'b1;
            else if (m_time > 0)  on = (m_par == 0);
            else                  on = (m_pre < CPS / 2);
            m_seg = on ? seg_of((m_time / p10[m_idx]) % 10) : 7'h7F;
            m_an  = 4'hF;
            if (on) m_an[3 - m_idx] = 1'b0;
            m_idx = (m_idx + 1) % 4;
            if (rst1) begin
                m_time = 15; m_pre = 0; m_par = 0;
            end else if (rst2) begin
                m_time = 150; m_pre = 0; m_par = 0;
            end else begin
                sum = 0;
                if (add[0] && !m_prev[0]) sum += 60;
                if (add[1] && !m_prev[1]) sum += 120;
                if (add[2] && !m_prev[2]) sum += 180;
                if (add[3] && !m_prev[3]) sum += 300;
                if (m_pre == CPS - 1) begin
                    m_pre = 0;
                    m_par = 1 - m_par;
                    if (m_time > 0) m_time--;
                end else begin
                    m_pre++;
                end
                m_time = (m_time + sum > 9999) ? 9999 : m_time + sum;
            end
            m_prev = add;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("val", {val1, val2, val3, val4}, to_bcd(m_time));
        check("seg", led_seg, m_seg);
        check("anodes", {a1, a2, a3, a4}, m_an);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic expect_val(input string tag, input logic [15:0] exp);
        check(tag, {val1, val2, val3, val4}, exp);
    endtask

    initial begin
        // Reset and 0 s flash
        rst = 1'b1; step(); rst = 1'b0;
        run(12);
        expect_val("rst_zero", 16'h0000);

        // add3 from zero, first decrement
        rst = 1'b1; step(); rst = 1'b0;
        add = 4'b0100; step(); add = 4'h0;
        expect_val("add3_180", 16'h0180);
        run(3);
        expect_val("add3_179", 16'h0179);
        run(12);

        // add4 held, then rst1 restarts the prescaler
        rst = 1'b1; step(); rst = 1'b0;
        add = 4'b1000; step();
        expect_val("add4_300", 16'h0300);
        run(9);
        add = 4'h0; step();
        rst1 = 1'b1; step(); rst1 = 1'b0;
        expect_val("rst1_15", 16'h0015);
        run(3);
        expect_val("rst1_hold", 16'h0015);
        step();
        expect_val("rst1_tick", 16'h0014);

        // Saturation at 9999
        rst2 = 1'b1; step(); rst2 = 1'b0;
        expect_val("rst2_150", 16'h0150);
        repeat (32) begin
            add = 4'b1000; step();
            add = 4'h0;    step();
        end
        add = 4'b1000; step();
        expect_val("sat_9999", 16'h9999);
        add = 4'h0; step();
        add = 4'b0001; step();
        expect_val("sat_hold", 16'h9999);
        add = 4'h0; step();

        // Simultaneous events
        rst = 1'b1; step(); rst = 1'b0;
        add = 4'b0011; step(); add = 4'h0;
        expect_val("add12_180", 16'h0180);
        step();
        add = 4'b1000; rst1 = 1'b1; step();
        expect_val("rst1_over_add4", 16'h0015);
        add = 4'h0; rst1 = 1'b0; step();
        rst = 1'b1; rst1 = 1'b1; rst2 = 1'b1; add = 4'hF; step();
        expect_val("rst_over_all", 16'h0000);
        rst = 1'b0; rst1 = 1'b0; rst2 = 1'b0; add = 4'h0;
        step();

        // Countdown to zero from 15 s
        rst1 = 1'b1; step(); rst1 = 1'b0;
        run(59);
        expect_val("count_one", 16'h0001);
        step();
        expect_val("count_zero", 16'h0000);
        run(12);

        // Random traffic: busy adds, then sparse adds to let countdowns run
        for (int phase = 0; phase < 2; phase++) begin
            add_rate = (phase == 0) ? 12 : 300;
            repeat (800) begin
                rst  = ($urandom_range(0, 99) == 0);
                rst1 = ($urandom_range(0, 79) == 0);
                rst2 = ($urandom_range(0, 79) == 0);
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, add_rate - 1) == 0) add[b] = ~add[b];
                step();
            end
        end
        rst = 1'b0; rst1 = 1'b0; rst2 = 1'b0; add = 4'h0;
        run(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_meter_core.md
PARKING_METER_CORE -- requirements
Module: parking_meter

Interface
REQ-001 Parameter CLKS_PER_SEC, default 100, clk cycles per one second of meter time; even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; also the "clear to 0 s" control.
REQ-004 add1  input  1  add 60 s.
REQ-005 add2  input  1  add 120 s.
REQ-006 add3  input  1  add 180 s.
REQ-007 add4  input  1  add 300 s.
REQ-008 rst1  input  1  load 15 s.
REQ-009 rst2  input  1  load 150 s.
REQ-010 led_seg  output  7  active-low segments; bit0=a through bit6=g, for the digit currently enabled.
REQ-011 a1..a4  output  1 each  active-low digit enables; a1 is the leftmost (thousands) digit, a4 the ones digit.
REQ-012 val1..val4  output  4 each  BCD digits of remaining time; val1 is thousands, val4 is ones; never blanked.

Function
REQ-013 Remaining time SHALL be held as 4 BCD digits, range 0..9999 s.
- Add inputs are rising-edge detected: each 0->1 transition acts exactly once, whatever the hold time.
- rst1 and rst2 act on every cycle they are high.
REQ-014 Priority SHALL be rst > rst1 > rst2 > adds.
- rst1 or rst2 overrides any adds in the same cycle.
REQ-015 Simultaneous add edges SHALL be summed.
- Result = min(time + sum, 9999).
REQ-016 A one-second prescaler SHALL count 0..CLKS_PER_SEC-1; a tick occurs when it wraps.
- On a tick with time > 0, time decrements by 1; at 0 it stays 0.
REQ-017 Tick coincident with an add: new time = min(max(time-1, 0) + sum, 9999).
REQ-018 rst1/rst2 SHALL clear the prescaler and the seconds-parity bit.
- The loaded value is therefore held for a full second; adds do not disturb the prescaler.
REQ-019 A seconds-parity bit SHALL toggle on every tick.
REQ-020 Display modes:
- time >= 180: display steadily on.
- 0 < time < 180: on while parity = 0, blank while parity = 1 (2 s period).
- time = 0: on while prescaler < CLKS_PER_SEC/2, blank otherwise (1 s period).
REQ-021 Digit scan: a 2-bit index SHALL advance every clk cycle (1 -> 2 -> 3 -> 4 -> 1).
- Exactly one of a1..a4 is low while on, and led_seg shows that digit's BCD value.
REQ-022 When blank, a1..a4 SHALL all be 1 and led_seg SHALL be 7'h7F.
- val1..val4 keep tracking the time regardless of blanking.
REQ-023 Segment encoding SHALL be standard 0-9; BCD codes 10-15 are unreachable and drive all segments off.
REQ-024 All outputs SHALL be registered; every change appears one cycle after the causing input edge.

Reset
REQ-025 On rst = 1 at a clk edge, the following SHALL be cleared:
- time = 0000, prescaler = 0, parity = 0, scan index = 0;
- add edge-detect history = 0.
REQ-026 Outputs the cycle after reset:
- val1..val4 = 0;
- led_seg = 7'h7F;
- a1..a4 = 1111 for that cycle;
- then the 0 s flash pattern of REQ-020 starts with the "on" half.
REQ-027 rst mid-countdown or mid-flash SHALL abandon all progress; there is no power-on state other than reset.

Structure
REQ-028 A shared package SHALL hold:
- add amounts 60/120/180/300;
- load values 15/150;
- MAX_TIME 9999;
- flash threshold 180;
- the segment-encoding constants.
REQ-029 One sub-module, bcd_to_7seg (4-bit BCD in, 7-bit active-low segments out), SHALL be instantiated once on the scan-multiplexed digit.
- BCD add/subtract with saturation lives in parking_meter.

Verification (CLKS_PER_SEC = 4 for speed)
REQ-030 Reset 0 s flash:
- Stimulus: rst, then idle 3 s.
- Response: val = 0000 throughout; display on 2 cycles, then blank 2 cycles, repeating.
REQ-031 add3 countdown:
- Stimulus: add3 pulse from 0 s.
- Response: val = 0180, steady on; after 1 tick val = 0179 and the 2 s flash begins (on 1 s, off 1 s).
REQ-032 add4 held:
- Stimulus: add4 held high for 10 cycles.
- Response: exactly +300 s.
- Then rst1: val = 0015, prescaler restarted, next decrement after exactly 4 cycles.
REQ-033 Saturation:
- Stimulus: rst2 (val = 0150); then add4 x 33 edges.
- Response: val saturates at 9999; a further add1 leaves 9999.
REQ-034 Simultaneous events:
- add1 and add2 edges in the same cycle: +180 s.
- rst1 with add4 in the same cycle: val = 0015.
- rst with any input in the same cycle: val = 0000.
REQ-035 Countdown to zero:
- Stimulus: rst1, wait 15 ticks.
- Response: val = 0000 and the 1 s flash starts.
- Also check: scan order a1..a4 and the digit-to-anode mapping in every mode.
